// File: rtl/atx_pll_recal_ctrl.sv
// ATX PLL recalibration controller: shares the PLL reconfig AVMM port with a user master
// and runs the bus-request / cal-trigger / settle / lock sequence. ATX_RECAL_TIMEOUT_EN adds a watchdog.
module atx_pll_recal_ctrl #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        reconfig_clk0,
  input  logic        reconfig_reset0,
  input  logic        recal_start,
  output logic        recal_busy,
  output logic        recal_done,
  output logic        recal_error,
  input  logic        user_write,
  input  logic        user_read,
  input  logic [10:0] user_address,
  input  logic [31:0] user_writedata,
  output logic [31:0] user_readdata,
  output logic        user_waitrequest,
  output logic        reconfig_write0,
  output logic        reconfig_read0,
  output logic [10:0] reconfig_address0,
  output logic [31:0] reconfig_writedata0,
  input  logic [31:0] reconfig_readdata0,
  input  logic        reconfig_waitrequest0,
  input  logic        pll_cal_busy,
  input  logic        pll_locked
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_BUS, S_POLL_GRANT, S_RD_CAL, S_WR_CAL, S_REL_BUS,
    S_SETTLE, S_WAIT_CAL, S_WAIT_LOCK, S_DONE, S_ERROR
  } state_t;

  localparam logic [10:0] ADDR_ARB    = 11'h000;
  localparam logic [10:0] ADDR_GRANT  = 11'h480;
  localparam logic [10:0] ADDR_CAL    = 11'h100;
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        gap_q, gap_d;
  logic        pend_q, pend_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  settle_q, settle_d;

  logic        seq_wr, seq_rd;
  logic [10:0] seq_addr;
  logic [31:0] seq_wdata;
  logic        acc_done;
  logic        user_strobe;
  logic        pass;

`ifdef ATX_RECAL_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        err_q, err_d;
`endif

  // gap_q forces one idle strobe cycle between back-to-back sequencer accesses
  always_comb begin
    seq_wr    = 1'b0;
    seq_rd    = 1'b0;
    seq_addr  = '0;
    seq_wdata = '0;
    case (state_q)
      S_REQ_BUS: begin
        seq_wr    = !gap_q;
        seq_addr  = ADDR_ARB;
        seq_wdata = 32'h0000_0002;
      end
      S_POLL_GRANT: begin
        seq_rd   = !gap_q;
        seq_addr = ADDR_GRANT;
      end
      S_RD_CAL: begin
        seq_rd   = !gap_q;
        seq_addr = ADDR_CAL;
      end
      S_WR_CAL: begin
        seq_wr    = !gap_q;
        seq_addr  = ADDR_CAL;
        seq_wdata = hold_q | 32'h0000_0002;
      end
      S_REL_BUS: begin
        seq_wr    = !gap_q;
        seq_addr  = ADDR_ARB;
        seq_wdata = 32'h0000_0001;
      end
      default: ;
    endcase
  end

  assign acc_done    = (seq_wr || seq_rd) && !reconfig_waitrequest0;
  assign user_strobe = user_write || user_read;

  always_comb begin
    state_d  = state_q;
    gap_d    = 1'b0;
    pend_d   = pend_q;
    hold_d   = hold_q;
    settle_d = settle_q;
`ifdef ATX_RECAL_TIMEOUT_EN
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (recal_start || pend_q) begin
`ifdef ATX_RECAL_TIMEOUT_EN
          if (recal_start) err_d = 1'b0;
`endif
          // a user transfer in flight finishes first; start on the cycle after it completes
          if (!user_strobe || !reconfig_waitrequest0) begin
            state_d = S_REQ_BUS;
            pend_d  = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_REQ_BUS: if (acc_done) begin
        state_d = S_POLL_GRANT;
        gap_d   = 1'b1;
      end
      S_POLL_GRANT: if (acc_done) begin
        gap_d = 1'b1;
        if (!reconfig_readdata0[2]) state_d = S_RD_CAL;
      end
      S_RD_CAL: if (acc_done) begin
        hold_d  = reconfig_readdata0;
        state_d = S_WR_CAL;
        gap_d   = 1'b1;
      end
      S_WR_CAL: if (acc_done) begin
        state_d = S_REL_BUS;
        gap_d   = 1'b1;
      end
      S_REL_BUS: if (acc_done) begin
        state_d  = S_SETTLE;
        settle_d = '0;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = S_WAIT_CAL;
        else settle_d = settle_q + 8'd1;
      end
      S_WAIT_CAL:  if (!pll_cal_busy) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: if (pll_locked) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      S_ERROR:     state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
`ifdef ATX_RECAL_TIMEOUT_EN
    // watchdog only fires while a wait state would otherwise hold
    if ((state_q inside {S_POLL_GRANT, S_WAIT_CAL, S_WAIT_LOCK}) && (state_d == state_q)) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        gap_d   = 1'b0;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
    if (state_d != state_q) to_cnt_d = '0;
`endif
  end

  always_ff @(posedge reconfig_clk0 or posedge reconfig_reset0) begin
    if (reconfig_reset0) begin
      state_q  <= S_IDLE;
      gap_q    <= 1'b0;
      pend_q   <= 1'b0;
      hold_q   <= '0;
      settle_q <= '0;
`ifdef ATX_RECAL_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      settle_q <= settle_d;
`ifdef ATX_RECAL_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // reset gates the bypass so the PLL port is quiet the instant reset rises
  assign pass = (state_q == S_IDLE) && !reconfig_reset0;

  assign reconfig_write0     = pass ? user_write     : seq_wr;
  assign reconfig_read0      = pass ? user_read      : seq_rd;
  assign reconfig_address0   = pass ? user_address   : seq_addr;
  assign reconfig_writedata0 = pass ? user_writedata : seq_wdata;
  assign user_readdata       = pass ? reconfig_readdata0 : 32'h0;
  assign user_waitrequest    = pass ? reconfig_waitrequest0 : 1'b1;

  assign recal_busy = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign recal_done = (state_q == S_DONE);
`ifdef ATX_RECAL_TIMEOUT_EN
  assign recal_error = err_q;
`else
  assign recal_error = 1'b0;
`endif

endmodule

// File: doc/atx_pll_recal_ctrl.md
ATX_PLL_RECAL_CTRL -- requirements
Module: atx_pll_recal_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, cycles waited after returning the bus before sampling pll_cal_busy (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, per-wait-state limit, used only when the timeout feature is compiled in.
REQ-003 SHALL have ports, clock and reset first:
- reconfig_clk0  in  1  sole clock.
- reconfig_reset0  in  1  asynchronous, active-high reset.
- recal_start  in  1  one-cycle recalibration request.
- recal_busy  out  1  sequence in progress.
- recal_done  out  1  one-cycle completion pulse.
- recal_error  out  1  sticky timeout flag.
- user_write / user_read  in  1  user AVMM strobes.
- user_address  in  11  user word address.
- user_writedata  in  32  user write data.
- user_readdata  out  32  user read data.
- user_waitrequest  out  1  user stall.
- reconfig_write0 / reconfig_read0  out  1  PLL AVMM strobes.
- reconfig_address0  out  11  PLL AVMM address.
- reconfig_writedata0  out  32  PLL AVMM write data.
- reconfig_readdata0  in  32  PLL AVMM read data.
- reconfig_waitrequest0  in  1  PLL AVMM stall.
- pll_cal_busy  in  1  PLL calibration active.
- pll_locked  in  1  PLL lock.

Function
REQ-004 SHALL implement states IDLE, REQ_BUS, POLL_GRANT, RD_CAL, WR_CAL, REL_BUS, SETTLE, WAIT_CAL, WAIT_LOCK, DONE, ERROR.
REQ-005 In IDLE, SHALL pass the user AVMM port combinationally to the PLL port, including all strobes, address, writedata, readdata and waitrequest.
REQ-006 Outside IDLE, SHALL hold user_waitrequest=1 and drive user_readdata=0.
REQ-007 SHALL accept recal_start in IDLE only, as follows:
- If no user strobe is asserted, SHALL accept it immediately.
- Otherwise SHALL latch it as pending and start on the first cycle after the user transfer completes (strobe high, reconfig_waitrequest0 low).
- recal_start in any other state SHALL be ignored.
REQ-008 SHALL hold every sequencer AVMM access stable until reconfig_waitrequest0 is sampled low. Read data SHALL be captured in that same cycle.
REQ-009 REQ_BUS: SHALL write 0x00000002 to address 0x000, then go to POLL_GRANT.
REQ-010 POLL_GRANT: SHALL read address 0x480. If bit2=0, SHALL go to RD_CAL; otherwise it SHALL reissue the read after 1 idle cycle.
REQ-011 RD_CAL: SHALL read address 0x100 into a 32-bit holding register.
REQ-012 WR_CAL: SHALL write (holding register | 0x00000002) to address 0x100.
REQ-013 REL_BUS: SHALL write 0x00000001 to address 0x000.
REQ-014 SETTLE: SHALL count SETTLE_CYCLES cycles, then go to WAIT_CAL.
REQ-015 WAIT_CAL: SHALL advance when pll_cal_busy=0.
REQ-016 WAIT_LOCK: SHALL advance to DONE when pll_locked=1.
REQ-017 DONE: SHALL assert recal_done for exactly 1 cycle, then return to IDLE.
REQ-018 recal_busy SHALL be 1 in every state except IDLE and ERROR.
REQ-019 Strobes SHALL be deasserted for at least 1 cycle between consecutive sequencer accesses.

Reset
REQ-020 Asserting reconfig_reset0 SHALL immediately force the following, including mid-transfer:
- state IDLE;
- all strobes 0, address 0, writedata 0;
- recal_busy=0, recal_done=0, recal_error=0;
- holding register, counters and pending flag cleared.
REQ-021 After reset release, the first state change SHALL occur on the first reconfig_clk0 rising edge.

Configuration
REQ-022 The macro ATX_RECAL_TIMEOUT_EN SHALL compile the timeout feature in or out.
REQ-023 With ATX_RECAL_TIMEOUT_EN defined:
- A counter SHALL restart on entry to POLL_GRANT, WAIT_CAL and WAIT_LOCK.
- Reaching TIMEOUT_CYCLES in any of those states SHALL go to ERROR.
- ERROR SHALL set recal_error=1 and drop all strobes.
- ERROR SHALL return to IDLE after 1 cycle, which restores user pass-through.
- recal_error SHALL clear on the next accepted recal_start.
REQ-024 Without ATX_RECAL_TIMEOUT_EN, SHALL have no timeout counter, SHALL tie recal_error to 0, never enter ERROR, and wait indefinitely in those states.

Verification
REQ-025 Nominal recalibration:
- Stimulus: pulse recal_start in IDLE; PLL model with waitrequest 1 cycle, 0x480 reads bit2=0, 0x100 reads 0x00000010, cal_busy high for 50 cycles after REL_BUS, lock 10 cycles after busy falls.
- Required response: accesses in order W000=0x2, R480, R100, W100=0x12, W000=0x1; then recal_done pulses once; recal_busy is 1 from the start cycle until DONE.
REQ-026 Grant polling: stimulus 0x480 returns bit2=1 for 3 reads, then 0. Required response: 4 reads of 0x480, each separated by at least 1 idle cycle, before R100.
REQ-027 User arbitration, part 1: stimulus user_read pending with waitrequest held for 5 cycles, recal_start pulsed at cycle 2. Required response: user read completes with correct data, then W000=0x2 begins on the next cycle.
REQ-028 User arbitration, part 2: stimulus user_write during WAIT_CAL. Required response: user_waitrequest=1 and no PLL strobe until IDLE.
REQ-029 Reset mid-operation: stimulus reconfig_reset0 asserted during WR_CAL. Required response: strobes drop asynchronously; after release recal_busy=0 and the user port passes through.
REQ-030 Timeout, with ATX_RECAL_TIMEOUT_EN and TIMEOUT_CYCLES=100: stimulus pll_locked held 0. Required response: recal_error=1 exactly 100 cycles after WAIT_LOCK entry; a following recal_start clears it.
